trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: XLEN, 64, datapath width of PC/CSR buses.
REQ-002 clock  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 excp_req  in  1  synchronous exception reported at commit.
REQ-005 excp_code  in  4  exception cause code, valid with excp_req.
REQ-006 excp_pc / excp_tval  in  XLEN each  faulting PC / trap value, valid with excp_req.
REQ-007 mret_req  in  1  committed mret.
REQ-008 itrp_pend  in  3  pending bits {ext[2], timer[1], soft[0]}.
REQ-009 itrp_en  in  3  mie enables, same bit order.
REQ-010 itrp_pc  in  XLEN  PC of next uncommitted instruction.
REQ-011 mem_busy  in  1  outstanding memory transaction.
REQ-012 mtvec / mepc / mstatus  in  XLEN each  current CSR read values.
REQ-013 csr_wr_en  out  1; csr_wr_sel  out  2 (0 mepc, 1 mcause, 2 mtval, 3 mstatus); csr_wr_data  out  XLEN.
REQ-014 redirect_valid  out  1; redirect_pc  out  XLEN; redirect_ready  in  1.
REQ-015 stall  out  1  freeze pipeline; flush  out  1  one-cycle pipeline kill.

Function
REQ-016 States SHALL be IDLE, DRAIN, WR_EPC, WR_CAUSE, WR_TVAL, WR_STAT, MRET_STAT, REDIR.
REQ-017 In IDLE, acceptance priority SHALL be excp_req > mret_req > interrupt; an interrupt is eligible iff mstatus[3]=1 and (itrp_pend & itrp_en)!=0.
REQ-018 Interrupt selection SHALL be ext (code 11) > soft (3) > timer (7).
REQ-019 On acceptance the block SHALL capture is_itrp, 4-bit code, epc (excp_pc, or itrp_pc for interrupts, or mepc with [1:0] cleared for mret), tval (excp_tval; 0 for interrupts) and go to DRAIN next cycle.
REQ-020 Requests outside IDLE SHALL be ignored; stall SHALL be 1 in every state except IDLE.
REQ-021 DRAIN SHALL hold while mem_busy=1; with mem_busy=0 it SHALL assert flush for exactly that cycle and go to WR_EPC (trap) or MRET_STAT (mret).
REQ-022 WR_EPC, WR_CAUSE, WR_TVAL, WR_STAT SHALL each last one cycle with csr_wr_en=1 and sel 0,1,2,3 in order, then REDIR.
REQ-023 mcause data SHALL be {is_itrp, 59'b0, code}; mtval data = captured tval.
REQ-024 WR_STAT data SHALL be current mstatus with bit7<=bit3, bit3<=0, bits[12:11]<=2'b11.
REQ-025 MRET_STAT SHALL write mstatus (sel 3) with bit3<=bit7, bit7<=1, bits[12:11]<=2'b11, then REDIR.
REQ-026 Trap target: mtvec[1:0]=01 and is_itrp -> {mtvec[63:2],2'b0}+4*code; otherwise {mtvec[63:2],2'b0}; mret target = captured epc.
REQ-027 REDIR SHALL hold redirect_valid=1 with stable redirect_pc until redirect_ready=1, then return to IDLE next cycle.
REQ-028 Arithmetic SHALL wrap modulo 2^XLEN.
REQ-029 Minimum latency (mem_busy=0, redirect_ready=1), accept at T: trap redirect handshake at T+6, IDLE at T+7; mret handshake at T+3, IDLE at T+4.

Reset
REQ-030 reset_n=0 SHALL force IDLE and all outputs 0 immediately, discarding any in-progress trap including mid-CSR sequence or pending redirect.

Verification
REQ-031 excp_req, code 2, excp_pc 0x8000_0010, tval 0x13, mtvec 0x8000_1000 -> writes mepc 0x8000_0010, mcause 2, mtval 0x13, mstatus MIE cleared; redirect 0x8000_1000 at T+6.
REQ-032 mstatus[3]=1, itrp_pend=3'b111, itrp_en=3'b111, mtvec 0x8000_1001 -> mcause 0x8000_0000_0000_000B, mtval 0, redirect 0x8000_102C.
REQ-033 excp_req and mret_req and enabled timer interrupt same cycle -> exception taken only; mret and interrupt ignored.
REQ-034 mem_busy held 5 cycles after accept -> flush only after mem_busy falls; redirect_ready low 3 cycles -> redirect_valid/pc stable throughout.
REQ-035 mret with mepc 0x8000_0042, mstatus bit7=1 -> mstatus write bit3=1 bit7=1, redirect 0x8000_0040 at T+3.
REQ-036 reset_n asserted during WR_CAUSE -> no further csr_wr_en or redirect; stall=0 immediately.

Source files
------------

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl -- machine-mode trap / mret sequencer
//
// Accepts one synchronous exception, committed mret or enabled interrupt
// while idle, drains outstanding memory traffic, flushes the pipeline,
// writes the machine CSRs one per cycle and redirects fetch to the trap
// vector (or back to mepc for mret). The pipeline is stalled for the whole
// sequence.
//
// Ports
//   clock, reset_n          sole clock (rising edge), async active-low reset
//   excp_req/code/pc/tval   synchronous exception reported at commit
//   mret_req                committed mret
//   itrp_pend, itrp_en      pending / enabled interrupts {ext, timer, soft}
//   itrp_pc                 PC of next uncommitted instruction
//   mem_busy                outstanding memory transaction
//   mtvec, mepc, mstatus    current CSR read values
//   csr_wr_en/sel/data      CSR write port (sel 0 mepc, 1 mcause, 2 mtval,
//                           3 mstatus)
//   redirect_valid/pc/ready fetch redirect handshake
//   stall                   freeze pipeline (high whenever not idle)
//   flush                   one-cycle pipeline kill when the drain completes
// ---------------------------------------------------------------------------
module trap_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            excp_req,
  input  logic [3:0]      excp_code,
  input  logic [XLEN-1:0] excp_pc,
  input  logic [XLEN-1:0] excp_tval,
  input  logic            mret_req,
  input  logic [2:0]      itrp_pend,
  input  logic [2:0]      itrp_en,
  input  logic [XLEN-1:0] itrp_pc,
  input  logic            mem_busy,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mstatus,
  output logic            csr_wr_en,
  output logic [1:0]      csr_wr_sel,
  output logic [XLEN-1:0] csr_wr_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            stall,
  output logic            flush
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_WR_EPC,
    S_WR_CAUSE,
    S_WR_TVAL,
    S_WR_STAT,
    S_MRET_STAT,
    S_REDIR
  } state_t;

  localparam logic [1:0] SEL_MEPC    = 2'd0;
  localparam logic [1:0] SEL_MCAUSE  = 2'd1;
  localparam logic [1:0] SEL_MTVAL   = 2'd2;
  localparam logic [1:0] SEL_MSTATUS = 2'd3;

  state_t          state;
  logic            is_itrp;
  logic            is_mret;
  logic [3:0]      code_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] data_q;   // write data for the mepc/mcause/mtval steps

  // Interrupt eligibility and fixed-priority selection ext > soft > timer.
  logic [2:0]      itrp_hit;
  logic            itrp_ok;
  logic [3:0]      itrp_code;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    itrp_hit  = itrp_pend & itrp_en;
    itrp_ok   = mstatus[3] && (itrp_hit != 3'b000);
    itrp_code = 4'd7;
    if (itrp_hit[2])      itrp_code = 4'd11;
    else if (itrp_hit[0]) itrp_code = 4'd3;
  end

  // Trap target: vectored mode only offsets interrupts; the add wraps
  // naturally at XLEN bits.
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] cause_val;

  always_comb begin
    trap_base   = mtvec & ~XLEN'(3);
    trap_target = trap_base;
    if (mtvec[1:0] == 2'b01 && is_itrp)
      trap_target = trap_base + {{(XLEN-6){1'b0}}, code_q, 2'b00};
    cause_val   = {is_itrp, {(XLEN-5){1'b0}}, code_q};
  end

  // mstatus updates use the live CSR value so the write reflects whatever
  // mstatus holds in the write cycle itself.
  //   trap: MPIE <= MIE, MIE <= 0, MPP <= 3
  //   mret: MIE <= MPIE, MPIE <= 1, MPP <= 3
  logic [XLEN-1:0] stat_trap;
  logic [XLEN-1:0] stat_mret;

  always_comb begin
    stat_trap        = mstatus;
    stat_trap[7]     = mstatus[3];
    stat_trap[3]     = 1'b0;
    stat_trap[12:11] = 2'b11;
    stat_mret        = mstatus;
    stat_mret[3]     = mstatus[7];
    stat_mret[7]     = 1'b1;
    stat_mret[12:11] = 2'b11;
  end

  assign csr_wr_data = (csr_wr_en && csr_wr_sel == SEL_MSTATUS)
                       ? (is_mret ? stat_mret : stat_trap)
                       : data_q;

  // Flush depends on the live mem_busy so it fires in the very cycle the
  // drain completes.
  assign flush = (state == S_DRAIN) && !mem_busy;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      is_itrp        <= 1'b0;
      is_mret        <= 1'b0;
      code_q         <= 4'd0;
      epc_q          <= '0;
      tval_q         <= '0;
      data_q         <= '0;
      csr_wr_en      <= 1'b0;
      csr_wr_sel     <= 2'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (excp_req) begin
            is_itrp <= 1'b0;
            is_mret <= 1'b0;
            code_q  <= excp_code;
            epc_q   <= excp_pc;
            tval_q  <= excp_tval;
            stall   <= 1'b1;
            state   <= S_DRAIN;
          end else if (mret_req) begin
            is_itrp <= 1'b0;
            is_mret <= 1'b1;
            code_q  <= 4'd0;
            epc_q   <= mepc & ~XLEN'(3);
            tval_q  <= '0;
            stall   <= 1'b1;
            state   <= S_DRAIN;
          end else if (itrp_ok) begin
            is_itrp <= 1'b1;
            is_mret <= 1'b0;
            code_q  <= itrp_code;
            epc_q   <= itrp_pc;
            tval_q  <= '0;
            stall   <= 1'b1;
            state   <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (!mem_busy) begin
            csr_wr_en <= 1'b1;
            if (is_mret) begin
              csr_wr_sel <= SEL_MSTATUS;
              data_q     <= '0;
              state      <= S_MRET_STAT;
            end else begin
              csr_wr_sel <= SEL_MEPC;
              data_q     <= epc_q;
              state      <= S_WR_EPC;
            end
          end
        end

        S_WR_EPC: begin
          csr_wr_sel <= SEL_MCAUSE;
          data_q     <= cause_val;
          state      <= S_WR_CAUSE;
        end

        S_WR_CAUSE: begin
          csr_wr_sel <= SEL_MTVAL;
          data_q     <= tval_q;
          state      <= S_WR_TVAL;
        end

        S_WR_TVAL: begin
          csr_wr_sel <= SEL_MSTATUS;
          data_q     <= '0;
          state      <= S_WR_STAT;
        end

        S_WR_STAT: begin
          csr_wr_en      <= 1'b0;
          csr_wr_sel     <= 2'd0;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
          state          <= S_REDIR;
        end

        S_MRET_STAT: begin
          csr_wr_en      <= 1'b0;
          csr_wr_sel     <= 2'd0;
          redirect_valid <= 1'b1;
          redirect_pc    <= epc_q;
          state          <= S_REDIR;
        end

        S_REDIR: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall          <= 1'b0;
            state          <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl -- directed self-checking bench for trap_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are sampled then.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clock;
  logic        reset_n;
  logic        excp_req;
  logic [3:0]  excp_code;
  logic [63:0] excp_pc;
  logic [63:0] excp_tval;
  logic        mret_req;
  logic [2:0]  itrp_pend;
  logic [2:0]  itrp_en;
  logic [63:0] itrp_pc;
  logic        mem_busy;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic [63:0] mstatus;
  logic        csr_wr_en;
  logic [1:0]  csr_wr_sel;
  logic [63:0] csr_wr_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;
  logic        stall;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  trap_ctrl #(.XLEN(64)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .excp_req       (excp_req),
    .excp_code      (excp_code),
    .excp_pc        (excp_pc),
    .excp_tval      (excp_tval),
    .mret_req       (mret_req),
    .itrp_pend      (itrp_pend),
    .itrp_en        (itrp_en),
    .itrp_pc        (itrp_pc),
    .mem_busy       (mem_busy),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .mstatus        (mstatus),
    .csr_wr_en      (csr_wr_en),
    .csr_wr_sel     (csr_wr_sel),
    .csr_wr_data    (csr_wr_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .stall          (stall),
    .flush          (flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    excp_req       = 1'b0;
    excp_code      = 4'd0;
    excp_pc        = 64'd0;
    excp_tval      = 64'd0;
    mret_req       = 1'b0;
    itrp_pend      = 3'b000;
    itrp_en        = 3'b000;
    itrp_pc        = 64'd0;
    mem_busy       = 1'b0;
    mtvec          = 64'd0;
    mepc           = 64'd0;
    mstatus        = 64'd0;
    redirect_ready = 1'b1;
  endtask

  // Entered in the DRAIN cycle with mem_busy already low. Walks the four CSR
  // writes, the redirect handshake (ready held low ready_delay cycles) and the
  // return to idle. Requests still asserted during the sequence must be
  // ignored; they are dropped before the machine returns to idle.
  task automatic follow_trap(input string tag, input logic [63:0] e_epc,
                             input logic [63:0] e_cause, input logic [63:0] e_tval,
                             input logic [63:0] e_stat, input logic [63:0] e_rpc,
                             input int ready_delay);
    logic [63:0] exp_data [4];
    exp_data[0] = e_epc;
    exp_data[1] = e_cause;
    exp_data[2] = e_tval;
    exp_data[3] = e_stat;

    checks++;
    if ({stall, flush, csr_wr_en} !== 3'b110) begin
      failures++;
      $display("FAIL %s drain: stall/flush/wr_en got %b expected 110", tag,
               {stall, flush, csr_wr_en});
    end

    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (csr_wr_en !== 1'b1 || csr_wr_sel !== 2'(i) || csr_wr_data !== exp_data[i]
          || redirect_valid !== 1'b0 || flush !== 1'b0) begin
        failures++;
        $display("FAIL %s csr_write%0d: en=%b sel=%0d data=%h rv=%b flush=%b expected en=1 sel=%0d data=%h rv=0 flush=0",
                 tag, i, csr_wr_en, csr_wr_sel, csr_wr_data, redirect_valid, flush, i, exp_data[i]);
      end
    end

    excp_req       = 1'b0;
    mret_req       = 1'b0;
    itrp_pend      = 3'b000;
    redirect_ready = (ready_delay == 0);
    tick();
    for (int k = 0; k <= ready_delay; k++) begin
      if (k == ready_delay) redirect_ready = 1'b1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== e_rpc || csr_wr_en !== 1'b0
          || stall !== 1'b1) begin
        failures++;
        $display("FAIL %s redirect%0d: rv=%b pc=%h wr_en=%b stall=%b expected rv=1 pc=%h wr_en=0 stall=1",
                 tag, k, redirect_valid, redirect_pc, csr_wr_en, stall, e_rpc);
      end
      if (k < ready_delay) tick();
    end

    tick();
    checks++;
    if ({stall, redirect_valid, csr_wr_en} !== 3'b000) begin
      failures++;
      $display("FAIL %s idle: stall/rv/wr_en got %b expected 000", tag,
               {stall, redirect_valid, csr_wr_en});
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stall, flush, csr_wr_en, redirect_valid} !== 4'b0000 || csr_wr_data !== 64'd0
        || redirect_pc !== 64'd0 || csr_wr_sel !== 2'd0) begin
      failures++;
      $display("FAIL reset: stall=%b flush=%b en=%b rv=%b data=%h pc=%h sel=%0d expected all zero",
               stall, flush, csr_wr_en, redirect_valid, csr_wr_data, redirect_pc, csr_wr_sel);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_exception();
    clear_inputs();
    mstatus   = 64'h8;
    mtvec     = 64'h8000_1000;
    excp_req  = 1'b1;
    excp_code = 4'd2;
    excp_pc   = 64'h8000_0010;
    excp_tval = 64'h13;
    tick();
    excp_req = 1'b0;
    follow_trap("excp", 64'h8000_0010, 64'd2, 64'h13, 64'h1880, 64'h8000_1000, 0);
  endtask

  task automatic test_interrupt();
    // All three pending: ext wins, vectored target base + 4*11.
    clear_inputs();
    mstatus   = 64'h8;
    mtvec     = 64'h8000_1001;
    itrp_pc   = 64'h8000_0200;
    itrp_en   = 3'b111;
    itrp_pend = 3'b111;
    tick();
    follow_trap("itrp_ext", 64'h8000_0200, 64'h8000_0000_0000_000B, 64'd0, 64'h1880,
                64'h8000_102C, 0);

    // soft beats timer.
    itrp_pc   = 64'h8000_0300;
    itrp_pend = 3'b011;
    tick();
    follow_trap("itrp_soft", 64'h8000_0300, 64'h8000_0000_0000_0003, 64'd0, 64'h1880,
                64'h8000_100C, 0);

    // Only timer enabled.
    itrp_pc   = 64'h8000_0400;
    itrp_en   = 3'b010;
    itrp_pend = 3'b110;
    tick();
    follow_trap("itrp_timer", 64'h8000_0400, 64'h8000_0000_0000_0007, 64'd0, 64'h1880,
                64'h8000_101C, 0);
  endtask

  task automatic test_itrp_blocked();
    clear_inputs();
    mstatus   = 64'h0;          // global MIE off
    itrp_en   = 3'b111;
    itrp_pend = 3'b111;
    tick();
    tick();
    checks++;
    if (stall !== 1'b0 || csr_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL itrp_mie_off: stall=%b wr_en=%b expected 0 0", stall, csr_wr_en);
    end
    mstatus   = 64'h8;
    itrp_en   = 3'b011;         // pending bit not enabled
    itrp_pend = 3'b100;
    tick();
    tick();
    checks++;
    if (stall !== 1'b0 || csr_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL itrp_masked: stall=%b wr_en=%b expected 0 0", stall, csr_wr_en);
    end
    itrp_pend = 3'b000;
  endtask

  task automatic test_priority();
    clear_inputs();
    mstatus   = 64'h8;
    mtvec     = 64'h8000_1001;  // vectored, but exceptions use the base
    mepc      = 64'h9000_0000;
    excp_req  = 1'b1;
    excp_code = 4'd5;
    excp_pc   = 64'h8000_0100;
    excp_tval = 64'h200;
    mret_req  = 1'b1;
    itrp_en   = 3'b010;
    itrp_pend = 3'b010;
    itrp_pc   = 64'h8000_0500;
    tick();
    // Requests remain high through the sequence and must be ignored.
    follow_trap("priority", 64'h8000_0100, 64'd5, 64'h200, 64'h1880, 64'h8000_1000, 0);
  endtask

  task automatic test_mem_busy_and_ready();
    clear_inputs();
    mstatus   = 64'h0;
    mtvec     = 64'h8000_1000;
    excp_req  = 1'b1;
    excp_code = 4'd4;
    excp_pc   = 64'h8000_0020;
    excp_tval = 64'hDEAD;
    mem_busy  = 1'b1;
    tick();
    excp_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({stall, flush, csr_wr_en} !== 3'b100) begin
        failures++;
        $display("FAIL busy_hold%0d: stall/flush/wr_en got %b expected 100", i,
                 {stall, flush, csr_wr_en});
      end
      if (i < 4) tick();
    end
    tick();
    mem_busy = 1'b0;
    #1;
    follow_trap("busy", 64'h8000_0020, 64'd4, 64'hDEAD, 64'h1800, 64'h8000_1000, 3);
  endtask

  task automatic test_mret();
    clear_inputs();
    mepc     = 64'h8000_0042;
    mstatus  = 64'h80;
    mret_req = 1'b1;
    tick();                     // T+1: DRAIN
    mret_req = 1'b0;
    checks++;
    if ({stall, flush, csr_wr_en} !== 3'b110) begin
      failures++;
      $display("FAIL mret_drain: stall/flush/wr_en got %b expected 110", {stall, flush, csr_wr_en});
    end
    tick();                     // T+2: MRET_STAT
    checks++;
    if (csr_wr_en !== 1'b1 || csr_wr_sel !== 2'd3 || csr_wr_data !== 64'h1888) begin
      failures++;
      $display("FAIL mret_stat: en=%b sel=%0d data=%h expected en=1 sel=3 data=%h",
               csr_wr_en, csr_wr_sel, csr_wr_data, 64'h1888);
    end
    tick();                     // T+3: REDIR handshake
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0040 || csr_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL mret_redirect: rv=%b pc=%h wr_en=%b expected rv=1 pc=%h wr_en=0",
               redirect_valid, redirect_pc, csr_wr_en, 64'h8000_0040);
    end
    tick();                     // T+4: IDLE
    checks++;
    if ({stall, redirect_valid} !== 2'b00) begin
      failures++;
      $display("FAIL mret_idle: stall/rv got %b expected 00", {stall, redirect_valid});
    end
  endtask

  task automatic test_reset_mid_sequence();
    clear_inputs();
    mstatus   = 64'h8;
    mtvec     = 64'h8000_1000;
    excp_req  = 1'b1;
    excp_code = 4'd6;
    excp_pc   = 64'h8000_0080;
    excp_tval = 64'h55;
    tick();                     // DRAIN
    excp_req = 1'b0;
    tick();                     // WR_EPC
    tick();                     // WR_CAUSE
    checks++;
    if (csr_wr_en !== 1'b1 || csr_wr_sel !== 2'd1 || csr_wr_data !== 64'd6) begin
      failures++;
      $display("FAIL mid_cause: en=%b sel=%0d data=%h expected en=1 sel=1 data=6",
               csr_wr_en, csr_wr_sel, csr_wr_data);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stall, flush, csr_wr_en, redirect_valid} !== 4'b0000 || csr_wr_data !== 64'd0) begin
      failures++;
      $display("FAIL mid_reset: stall=%b flush=%b en=%b rv=%b data=%h expected zeros",
               stall, flush, csr_wr_en, redirect_valid, csr_wr_data);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({stall, csr_wr_en, redirect_valid} !== 3'b000) begin
        failures++;
        $display("FAIL post_reset%0d: stall/wr_en/rv got %b expected 000", i,
                 {stall, csr_wr_en, redirect_valid});
      end
    end
  endtask

  task automatic test_back_to_back();
    // An exception presented in the idle cycle right after a redirect.
    clear_inputs();
    mstatus   = 64'h8;
    mtvec     = 64'h8000_2000;
    excp_req  = 1'b1;
    excp_code = 4'd8;
    excp_pc   = 64'h8000_0600;
    excp_tval = 64'h0;
    tick();
    follow_trap("b2b_first", 64'h8000_0600, 64'd8, 64'd0, 64'h1880, 64'h8000_2000, 0);
    excp_req  = 1'b1;
    excp_code = 4'd13;
    excp_pc   = 64'h8000_0700;
    excp_tval = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    excp_req = 1'b0;
    follow_trap("b2b_second", 64'h8000_0700, 64'd13, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1880,
                64'h8000_2000, 1);
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_exception();
    test_interrupt();
    test_itrp_blocked();
    test_priority();
    test_mem_busy_and_ready();
    test_mret();
    test_reset_mid_sequence();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
